// File: rtl/fft_seq_ctrl_pkg.sv
// Shared types and helpers for the FFT sequencing controller.
// State encoding plus a closed-form run length used by checkers.
package fft_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddr  = 3'd1,
    StBfly  = 3'd2,
    StWait  = 3'd3,
    StWrite = 3'd4,
    StPost  = 3'd5,
    StAdv   = 3'd6,
    StDone  = 3'd7
  } state_e;

  localparam int unsigned FixedStepCycles = 5;

  // Cycles from the enable-sampling edge until DONE is entered.
  function automatic int unsigned total_cycles(input int unsigned log2n,
                                               input int unsigned bfly_wait);
    return log2n * (32'd1 << (log2n - 1)) * (FixedStepCycles + bfly_wait);
  endfunction

endpackage

// File: rtl/fft_iter_counter.sv
// Stage / butterfly-index counter for the FFT sequencer.
// clear_i has priority over inc_i; bfly wraps to 0 and bumps stage.
module fft_iter_counter #(
  parameter int unsigned LOG2_N  = 11,
  parameter int unsigned STAGE_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                clear_i,
  output logic [STAGE_W-1:0]  stage_o,
  output logic [LOG2_N-2:0]   bfly_o,
  output logic                last_bfly_o,
  output logic                last_stage_o
);

  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [LOG2_N-2:0]  bfly_q, bfly_d;

  assign last_bfly_o  = (bfly_q == '1);
  assign last_stage_o = (stage_q == STAGE_W'(LOG2_N - 1));

  always_comb begin
    stage_d = stage_q;
    bfly_d  = bfly_q;
    if (clear_i) begin
      stage_d = '0;
      bfly_d  = '0;
    end else if (inc_i) begin
      if (last_bfly_o) begin
        bfly_d  = '0;
        stage_d = stage_q + STAGE_W'(1);
      end else begin
        bfly_d = bfly_q + (LOG2_N - 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
      bfly_q  <= '0;
    end else begin
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
    end
  end

  assign stage_o = stage_q;
  assign bfly_o  = bfly_q;

endmodule

// File: rtl/fft_seq_ctrl.sv
// Parametrised radix-2 FFT sequencing controller (FSM, wait counter, output regs).
// Optional ADDR-state stall input enabled by defining FFT_SEQ_CTRL_HOLD_EN.
module fft_seq_ctrl
  import fft_seq_ctrl_pkg::*;
#(
  parameter int unsigned LOG2_N    = 11,
  parameter int unsigned BFLY_WAIT = 2,
  parameter int unsigned STAGE_W   = 4
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               enable_i,
  input  logic               abort_i,
`ifdef FFT_SEQ_CTRL_HOLD_EN
  input  logic               hold_i,
`endif
  output logic               addr_enable_o,
  output logic               addr_writemode_o,
  output logic               butterfly_enable_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic [LOG2_N-2:0]  bfly_idx_o
);

  localparam int unsigned WaitW = (BFLY_WAIT > 1) ? $clog2(BFLY_WAIT) : 1;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               cnt_inc, cnt_clear;
  logic               last_bfly, last_stage;
  logic               addr_en_q, wr_mode_q, bfly_en_q, busy_q, done_q;

  logic addr_stall;
`ifdef FFT_SEQ_CTRL_HOLD_EN
  assign addr_stall = hold_i;
`else
  assign addr_stall = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cnt_inc   = 1'b0;
    cnt_clear = 1'b0;
    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      wait_d    = '0;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle:  if (enable_i && !abort_i) state_d = StAddr;
        StAddr:  if (!addr_stall) state_d = StBfly;
        StBfly: begin
          state_d = StWait;
          wait_d  = '0;
        end
        StWait: begin
          if (wait_q == WaitW'(BFLY_WAIT - 1)) begin
            state_d = StWrite;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StWrite: state_d = StPost;
        StPost:  state_d = StAdv;
        StAdv: begin
          // Final butterfly clears the counters instead of wrapping them.
          if (last_bfly && last_stage) begin
            state_d   = StDone;
            cnt_clear = 1'b1;
          end else begin
            state_d = StAddr;
            cnt_inc = 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      addr_en_q <= 1'b0;
      wr_mode_q <= 1'b0;
      bfly_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      addr_en_q <= (state_d == StAdv);
      wr_mode_q <= (state_d == StWrite);
      bfly_en_q <= (state_d == StBfly);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
    end
  end

  fft_iter_counter #(
    .LOG2_N  (LOG2_N),
    .STAGE_W (STAGE_W)
  ) u_iter_counter (
    .clk_i        (clock_i),
    .rst_ni       (reset_ni),
    .inc_i        (cnt_inc),
    .clear_i      (cnt_clear),
    .stage_o      (stage_o),
    .bfly_o       (bfly_idx_o),
    .last_bfly_o  (last_bfly),
    .last_stage_o (last_stage)
  );

  assign addr_enable_o      = addr_en_q;
  assign addr_writemode_o   = wr_mode_q;
  assign butterfly_enable_o = bfly_en_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl on an 8-point configuration.
// Expected (stage, bfly_idx) pairs are queued at start and popped on each butterfly_enable.
module tb_fft_seq_ctrl;
  import fft_seq_ctrl_pkg::*;

  localparam int unsigned LOG2_N    = 3;
  localparam int unsigned BFLY_WAIT = 2;
  localparam int unsigned STAGE_W   = 4;
  localparam int unsigned BW        = LOG2_N - 1;
  localparam int unsigned NBFLY     = LOG2_N * (1 << BW);

  typedef struct packed {
    logic [STAGE_W-1:0] s;
    logic [BW-1:0]      b;
  } sb_t;

  logic               clk, reset_n, enable, abort, hold;
  logic               addr_enable, addr_writemode, butterfly_enable, busy, done;
  logic [STAGE_W-1:0] stage;
  logic [BW-1:0]      bfly_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int addr_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int total;
  sb_t sbq[$];

  fft_seq_ctrl #(
    .LOG2_N    (LOG2_N),
    .BFLY_WAIT (BFLY_WAIT),
    .STAGE_W   (STAGE_W)
  ) dut (
    .clock_i            (clk),
    .reset_ni           (reset_n),
    .enable_i           (enable),
    .abort_i            (abort),
`ifdef FFT_SEQ_CTRL_HOLD_EN
    .hold_i             (hold),
`endif
    .addr_enable_o      (addr_enable),
    .addr_writemode_o   (addr_writemode),
    .butterfly_enable_o (butterfly_enable),
    .busy_o             (busy),
    .done_o             (done),
    .stage_o            (stage),
    .bfly_idx_o         (bfly_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every butterfly launch must match the next queued index pair.
  initial begin
    sb_t exp;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (butterfly_enable === 1'b1) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL bfly_unexpected: stage=%0d bfly=%0d with empty scoreboard at cyc %0d",
                     stage, bfly_idx, cyc);
          end else begin
            exp = sbq.pop_front();
            if (stage !== exp.s || bfly_idx !== exp.b) begin
              errors++;
              $display("FAIL bfly_index: got (%0d,%0d) expected (%0d,%0d) at cyc %0d",
                       stage, bfly_idx, exp.s, exp.b, cyc);
            end
          end
        end
        if (addr_enable === 1'b1) addr_cnt++;
        if (addr_writemode === 1'b1) wr_cnt++;
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  task automatic push_run();
    for (int s = 0; s < LOG2_N; s++) begin
      for (int b = 0; b < (1 << BW); b++) begin
        sbq.push_back(sb_t'{s: STAGE_W'(s), b: BW'(b)});
      end
    end
  endtask

  // Raise enable at a negedge; returns the index of the sampling edge.
  task automatic start_run(output int start);
    @(negedge clk);
    enable = 1'b1;
    push_run();
    start = cyc + 1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    abort   = 1'b0;
    hold    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({addr_enable, addr_writemode, butterfly_enable, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {addr_enable, addr_writemode, butterfly_enable, busy, done});
    end
    checks++;
    if (stage !== '0 || bfly_idx !== '0) begin
      errors++;
      $display("FAIL reset_counters: got (%0d,%0d) expected (0,0)", stage, bfly_idx);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_full_run();
    int start, at, a0, w0;
    a0 = addr_cnt;
    w0 = wr_cnt;
    start_run(start);
    wait_done(total + 20, at);
    checks++;
    if (at - start != total) begin
      errors++;
      $display("FAIL run_latency: done at +%0d expected +%0d", at - start, total);
    end
    checks++;
    if (stage !== '0 || bfly_idx !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_state: stage=%0d bfly=%0d busy=%b expected 0,0,1", stage, bfly_idx, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: busy=%b done=%b expected 0,0", busy, done);
    end
    checks++;
    if (addr_cnt - a0 != NBFLY || wr_cnt - w0 != NBFLY) begin
      errors++;
      $display("FAIL pulse_counts: addr=%0d wr=%0d expected %0d each",
               addr_cnt - a0, wr_cnt - w0, NBFLY);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_bfly: %0d left expected 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_abort();
    int start, d0;
    d0 = done_cnt;
    start_run(start);
    while (cyc < start + 19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({addr_enable, addr_writemode, butterfly_enable, busy, done} !== 5'b0 ||
        stage !== '0 || bfly_idx !== '0) begin
      errors++;
      $display("FAIL abort_clear: outs=%b stage=%0d bfly=%0d expected all 0",
               {addr_enable, addr_writemode, butterfly_enable, busy, done}, stage, bfly_idx);
    end
    checks++;
    if (sbq.size() != NBFLY - 3) begin
      errors++;
      $display("FAIL abort_bfly_count: left=%0d expected %0d", sbq.size(), NBFLY - 3);
    end
    sbq.delete();
    repeat (100) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d busy=%b expected 0,0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    enable = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins_idle: busy=%b expected 0", busy);
    end
    enable = 1'b0;
    abort  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int start;
    start_run(start);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({addr_enable, addr_writemode, butterfly_enable, busy, done} !== 5'b0 ||
        stage !== '0 || bfly_idx !== '0) begin
      errors++;
      $display("FAIL async_reset: outs=%b stage=%0d bfly=%0d expected all 0",
               {addr_enable, addr_writemode, butterfly_enable, busy, done}, stage, bfly_idx);
    end
    sbq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int at1, at2;
    @(negedge clk);
    enable = 1'b1;
    push_run();
    push_run();
    wait_done(total + 20, at1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b expected 0,0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b expected 1", busy);
    end
    enable = 1'b0;
    wait_done(total + 20, at2);
    checks++;
    if (at1 < 0 || at2 - (at1 + 2) != total) begin
      errors++;
      $display("FAIL b2b_latency: second run +%0d expected +%0d", at2 - (at1 + 2), total);
    end
    @(negedge clk);
    checks++;
    if (sbq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: left=%0d busy=%b expected 0,0", sbq.size(), busy);
    end
    sbq.delete();
  endtask

`ifdef FFT_SEQ_CTRL_HOLD_EN
  task automatic test_hold();
    int start, at;
    start_run(start);
    while (cyc < start + 14) @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (butterfly_enable !== 1'b0 || busy !== 1'b1 || stage !== '0 || bfly_idx !== BW'(2)) begin
        errors++;
        $display("FAIL hold_stall: bfly_en=%b busy=%b (%0d,%0d) expected 0,1,(0,2)",
                 butterfly_enable, busy, stage, bfly_idx);
      end
    end
    hold = 1'b0;
    wait_done(total + 40, at);
    checks++;
    if (at - start != total + 5) begin
      errors++;
      $display("FAIL hold_latency: done at +%0d expected +%0d", at - start, total + 5);
    end
    repeat (2) @(negedge clk);
    sbq.delete();
  endtask
`endif

  initial begin
    total = int'(total_cycles(LOG2_N, BFLY_WAIT));
    test_reset();
    test_full_run();
    test_abort();
    test_abort_idle();
    test_async_reset();
    test_back_to_back();
`ifdef FFT_SEQ_CTRL_HOLD_EN
    test_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
